// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants for the seven-segment scan controller
package seg_pkg;

    // Active-low segment patterns {dp, g..a}; bit 7 is always 1 so the decimal
    // point can be merged in with a simple AND.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // All digit selects released; callers slice down to their digit count.
    localparam logic [7:0] SEL_OFF = 8'hFF;

    // Active-low one-hot select for a digit index.
    function automatic logic [7:0] sel_of(input logic [2:0] digit);
        return ~(8'd1 << digit);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - nibble plus decimal point to active-low segments
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    // Table bit 7 is 1, so ANDing with ~dp yields the active-low decimal point.
    assign seg = HEX_SEG[nibble] & {~dp, 7'h7F};

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scanner with tear-free updates
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS       = 6,
    parameter int SCAN_TICKS   = 50_000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   num,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  blank_lz,
    input  logic [2:0]            bright,
    input  logic                  load,
    output logic                  pending,
    output logic                  frame_done,
    output logic [DIGITS-1:0]     sel,
    output logic [7:0]            seg
);

    localparam int DIV_MAX = SCAN_TICKS / 8 - 1;
    localparam int DW      = $clog2(SCAN_TICKS / 8);
    localparam int FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DW-1:0]         div;
    logic [2:0]            sub;
    logic [2:0]            idx;
    logic [FW-1:0]         fcnt;
    logic                  phase;
    logic [4*DIGITS-1:0]   pend_num, shad_num;
    logic [DIGITS-1:0]     pend_dp, shad_dp, pend_blink, shad_blink;
    logic                  tick, wrap;
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_blink, upper_zero;
    logic [7:0]            dec_seg, sel_full;
    logic [DIGITS-1:0]     sel_nxt;
    logic [7:0]            seg_nxt;

    assign tick     = (sub == 3'd7) && (div == DW'(DIV_MAX));
    assign wrap     = tick && (idx == 3'(DIGITS - 1));
    assign sel_full = sel_of(idx);

    // Sub-slot divider: eight equal sub-slots per digit slot for PWM dimming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            sub <= '0;
        end else if (div == DW'(DIV_MAX)) begin
            div <= '0;
            sub <= sub + 3'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Digit index and frame-wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (wrap)
                idx <= '0;
            else if (tick)
                idx <= idx + 3'd1;
        end
    end

    // Blink phase toggles after BLINK_FRAMES frame wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // Double buffer: commit uses the old pending copy, so a load on the wrap
    // cycle lands in pending and waits for the following wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_num   <= '0;
            pend_dp    <= '0;
            pend_blink <= '0;
            shad_num   <= '0;
            shad_dp    <= '0;
            shad_blink <= '0;
            pending    <= 1'b0;
        end else begin
            if (wrap && pending) begin
                shad_num   <= pend_num;
                shad_dp    <= pend_dp;
                shad_blink <= pend_blink;
            end
            if (load) begin
                pend_num   <= num;
                pend_dp    <= dp;
                pend_blink <= blink_en;
                pending    <= 1'b1;
            end else if (wrap) begin
                pending    <= 1'b0;
            end
        end
    end

    // Current digit's shadow fields and whether it and all higher digits are zero.
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blink  = 1'b0;
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i == int'(idx)) begin
                cur_nib   = shad_num[4*i +: 4];
                cur_dp    = shad_dp[i];
                cur_blink = shad_blink[i];
            end
            if (i >= int'(idx) && shad_num[4*i +: 4] != 4'h0)
                upper_zero = 1'b0;
        end
    end

    seg_hex_decode u_dec (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .seg    (dec_seg)
    );

    // Next output: dark outside the brightness window or during a blink-off phase.
    always_comb begin
        sel_nxt = SEL_OFF[DIGITS-1:0];
        seg_nxt = SEG_OFF;
        if (sub <= bright && !(phase && cur_blink)) begin
            sel_nxt = sel_full[DIGITS-1:0];
            if (blank_lz && idx != 3'd0 && upper_zero)
                seg_nxt = {~cur_dp, 7'h7F};
            else
                seg_nxt = dec_seg;
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= SEL_OFF[DIGITS-1:0];
            seg <= SEG_OFF;
        end else begin
            sel <= sel_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    localparam int D  = 6;
    localparam int ST = 16;
    localparam int BF = 2;
    localparam int FR = D * ST;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] num = '0;
    logic [5:0]  dp = '0;
    logic [5:0]  blink_en = '0;
    logic        blank_lz = 1'b0;
    logic [2:0]  bright = 3'd7;
    logic        load = 1'b0;
    logic        pending, frame_done;
    logic [5:0]  sel;
    logic [7:0]  seg;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIGITS(D), .SCAN_TICKS(ST), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .num        (num),
        .dp         (dp),
        .blink_en   (blink_en),
        .blank_lz   (blank_lz),
        .bright     (bright),
        .load       (load),
        .pending    (pending),
        .frame_done (frame_done),
        .sel        (sel),
        .seg        (seg)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] hex_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    int          n;
    logic [23:0] sh_num, pd_num;
    logic [5:0]  sh_dp, pd_dp, sh_bl, pd_bl;
    logic        pd_flag;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        sh_num = '0; sh_dp = '0; sh_bl = '0;
        pd_num = '0; pd_dp = '0; pd_bl = '0;
        pd_flag = 1'b0;
    endtask

    // One clock: predict from the cycle count and shadow contents, then check.
    task automatic cycle();
        int          idx, sub;
        bit          ph;
        logic [5:0]  es;
        logic [7:0]  eg;
        logic [23:0] up;
        idx = (n / ST) % D;
        sub = (n % ST) / (ST / 8);
        ph  = ((n / (FR * BF)) % 2) == 1;
        if (sub > int'(bright) || (ph && sh_bl[idx])) begin
            es = 6'h3F;
            eg = 8'hFF;
        end else begin
            es = ~(6'd1 << idx);
            up = sh_num >> (4 * idx);
            if (blank_lz && idx > 0 && up == 24'd0)
                eg = {~sh_dp[idx], 7'h7F};
            else
                eg = {~sh_dp[idx], hex_tab[up[3:0]][6:0]};
        end
        @(posedge clk);
        #1;
        n++;
        if (n % FR == 0 && pd_flag) begin
            sh_num = pd_num; sh_dp = pd_dp; sh_bl = pd_bl;
            pd_flag = 1'b0;
        end
        if (load) begin
            pd_num = num; pd_dp = dp; pd_bl = blink_en;
            pd_flag = 1'b1;
        end
        check("sel", 32'(sel), 32'(es));
        check("seg", 32'(seg), 32'(eg));
        check("frame_done", 32'(frame_done), 32'(n % FR == 0));
        check("pending", 32'(pending), 32'(pd_flag));
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic run_to(input int phase_pos);
        for (int i = 0; i < FR && (n % FR) != phase_pos; i++) cycle();
    endtask

    task automatic do_load(input logic [23:0] v, input logic [5:0] d, input logic [5:0] b);
        num = v; dp = d; blink_en = b; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic rand_load();
        int          k;
        logic [31:0] m;
        k = $urandom_range(0, 6);
        m = (32'd1 << (4 * k)) - 32'd1;
        do_load(24'($urandom & m), 6'($urandom), 6'($urandom));
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_sel", 32'(sel), 32'h3F);
        check("reset_seg", 32'(seg), 32'hFF);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        check("reset_pending", 32'(pending), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic scan of 0x123456 at full brightness
        run(5);
        do_load(24'h123456, 6'd0, 6'd0);
        run(2 * FR + 10);

        // two loads mid-frame, last one wins at the wrap
        run_to(30);
        do_load(24'h000000, 6'd0, 6'd0);
        run(10);
        do_load(24'h00000A, 6'd0, 6'd0);
        run(FR + 20);

        // load on the frame_done cycle, and on the wrap edge itself
        run_to(0);
        do_load(24'h00BEEF, 6'b000010, 6'd0);
        run(FR + 5);
        run_to(FR - 1);
        do_load(24'h000042, 6'd0, 6'd0);
        run(2 * FR + 5);

        // leading-zero blanking with a decimal point
        blank_lz = 1'b1;
        do_load(24'h000070, 6'b000100, 6'd0);
        run(2 * FR);
        do_load(24'h000070, 6'b010000, 6'd0);
        run(2 * FR);

        // blink and dimming
        bright = 3'd1;
        do_load(24'h000123, 6'd0, 6'b000001);
        run(5 * FR);
        bright = 3'd7;

        // randomized traffic with live-input changes
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 59) == 0) rand_load();
            else begin
                if ($urandom_range(0, 199) == 0) bright = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 149) == 0) blank_lz = ~blank_lz;
                cycle();
            end
        end

        // mid-frame reset with a pending load outstanding
        bright = 3'd7;
        run_to(40);
        do_load(24'h777777, 6'h3F, 6'h3F);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_sel", 32'(sel), 32'h3F);
        check("midreset_seg", 32'(seg), 32'hFF);
        check("midreset_pending", 32'(pending), 32'd0);
        check("midreset_frame_done", 32'(frame_done), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(2 * FR);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
